// File: rtl/burst_read_ctrl.sv
// rtl/burst_read_ctrl.sv - burst read sequencer for a wait-stated memory port
module burst_read_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int LEN_W     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              go,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              ws,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic              beat,
    output logic              ds,
    output logic              err,
    output logic              busy
);

    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        READ  = 4'b0010,
        DELAY = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [RTY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic               abort_q, abort_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        retry_cnt_d = retry_cnt_q;
        abort_d     = abort_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    addr_d      = base_addr;
                    len_d       = burst_len;
                    beat_cnt_d  = '0;
                    retry_cnt_d = '0;
                    abort_d     = 1'b0;
                    state_d     = READ;
                end
            end
            READ: state_d = DELAY;
            DELAY: begin
                if (ws) begin
                    // Retry re-reads the same address; the limit turns into an abort.
                    if (retry_cnt_q < RTY_MAX) begin
                        retry_cnt_d = retry_cnt_q + RTY_W'(1);
                        state_d     = READ;
                    end else begin
                        abort_d = 1'b1;
                        state_d = DONE;
                    end
                end else if (beat_cnt_q == len_q) begin
                    state_d = DONE;
                end else begin
                    addr_d      = addr_q + ADDR_W'(1);
                    beat_cnt_d  = beat_cnt_q + LEN_W'(1);
                    retry_cnt_d = '0;
                    state_d     = READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            retry_cnt_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            retry_cnt_q <= retry_cnt_d;
            abort_q     <= abort_d;
        end
    end

    // Decoded per legal state so an illegal encoding drives every output low.
    logic st_read, st_delay, st_done;
    assign st_read  = (state_q == READ);
    assign st_delay = (state_q == DELAY);
    assign st_done  = (state_q == DONE);

    assign rd   = st_read | st_delay;
    assign beat = st_delay & ~ws;
    assign ds   = st_done;
    assign err  = st_done & abort_q;
    assign busy = st_read | st_delay | st_done;
    assign addr = addr_q;

endmodule

// File: tb/tb_burst_read_ctrl.sv
// tb/tb_burst_read_ctrl.sv - directed self-checking bench for burst_read_ctrl
module tb_burst_read_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       go;
    logic [7:0] base_addr;
    logic [3:0] burst_len;
    logic       ws;
    logic       rd;
    logic [7:0] addr;
    logic       beat;
    logic       ds;
    logic       err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // {rd, beat, ds, err, busy} and addr per cycle of the last burst
    logic [4:0] obs_sig  [64];
    logic [7:0] obs_addr [64];

    burst_read_ctrl #(.ADDR_W(8), .LEN_W(4), .MAX_RETRY(3)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .go        (go),
        .base_addr (base_addr),
        .burst_len (burst_len),
        .ws        (ws),
        .rd        (rd),
        .addr      (addr),
        .beat      (beat),
        .ds        (ds),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Starts at posedge+1; cycle 0 presents go. Inputs other than go are
    // scrambled after cycle 0 to show they are not re-captured.
    task automatic run(input logic [7:0] base, input logic [3:0] len, input int ncyc,
                       input logic [63:0] ws_mask, input logic [63:0] go_mask);
        for (int k = 0; k < ncyc; k++) begin
            go        = (k == 0) || go_mask[k];
            base_addr = (k == 0) ? base : ~base;
            burst_len = (k == 0) ? len : ~len;
            ws        = ws_mask[k];
            #2;
            obs_sig[k]  = {rd, beat, ds, err, busy};
            obs_addr[k] = addr;
            @(posedge clk);
            #1;
        end
        go = 1'b0;
        ws = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; go = 1'b0; base_addr = 8'h00; burst_len = 4'h0; ws = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({rd, beat, ds, err, busy} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000", {rd, beat, ds, err, busy});
        end
        checks++;
        if (addr !== 8'h00) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=00", addr);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_beat();
        logic [4:0] e [5] = '{5'b00000, 5'b10001, 5'b11001, 5'b00101, 5'b00000};
        run(8'h10, 4'h0, 5, 64'h0, 64'h0);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs_sig[k] !== e[k]) begin
                failures++;
                $display("FAIL single_sig cyc=%0d got=%b exp=%b", k, obs_sig[k], e[k]);
            end
        end
        checks++;
        if (obs_addr[2] !== 8'h10) begin
            failures++;
            $display("FAIL single_addr got=%h exp=10", obs_addr[2]);
        end
    endtask

    task automatic test_four_beats();
        logic [4:0] e [11] = '{5'b00000, 5'b10001, 5'b11001, 5'b10001, 5'b11001, 5'b10001,
                               5'b11001, 5'b10001, 5'b11001, 5'b00101, 5'b00000};
        run(8'h20, 4'h3, 11, 64'h0, 64'h0);
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (obs_sig[k] !== e[k]) begin
                failures++;
                $display("FAIL four_sig cyc=%0d got=%b exp=%b", k, obs_sig[k], e[k]);
            end
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (obs_addr[2 + 2 * b] !== 8'h20 + 8'(b)) begin
                failures++;
                $display("FAIL four_addr beat=%0d got=%h exp=%h", b, obs_addr[2 + 2 * b], 8'h20 + 8'(b));
            end
        end
    endtask

    task automatic test_retry_once();
        logic [4:0] e [9] = '{5'b00000, 5'b10001, 5'b10001, 5'b10001, 5'b11001,
                              5'b10001, 5'b11001, 5'b00101, 5'b00000};
        logic [7:0] ea [4] = '{8'h20, 8'h20, 8'h21, 8'h21};
        run(8'h20, 4'h1, 9, 64'h4, 64'h0);
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (obs_sig[k] !== e[k]) begin
                failures++;
                $display("FAIL retry_sig cyc=%0d got=%b exp=%b", k, obs_sig[k], e[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_addr[3 + k] !== ea[k]) begin
                failures++;
                $display("FAIL retry_addr cyc=%0d got=%h exp=%h", 3 + k, obs_addr[3 + k], ea[k]);
            end
        end
    endtask

    task automatic test_abort();
        logic [4:0] e [11] = '{5'b00000, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001,
                               5'b10001, 5'b10001, 5'b10001, 5'b00111, 5'b00000};
        run(8'h30, 4'h0, 11, '1, 64'h0);
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (obs_sig[k] !== e[k]) begin
                failures++;
                $display("FAIL abort_sig cyc=%0d got=%b exp=%b", k, obs_sig[k], e[k]);
            end
        end
    endtask

    task automatic test_wrap_ignore_go();
        logic [4:0] e [10] = '{5'b00000, 5'b10001, 5'b11001, 5'b10001, 5'b11001,
                               5'b10001, 5'b11001, 5'b00101, 5'b00000, 5'b00000};
        logic [7:0] ea [4] = '{8'hFE, 8'hFF, 8'h00, 8'h00};
        run(8'hFE, 4'h2, 10, 64'h0, 64'hAA);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (obs_sig[k] !== e[k]) begin
                failures++;
                $display("FAIL wrap_sig cyc=%0d got=%b exp=%b", k, obs_sig[k], e[k]);
            end
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (obs_addr[2 + 2 * b] !== ea[b]) begin
                failures++;
                $display("FAIL wrap_addr cyc=%0d got=%h exp=%h", 2 + 2 * b, obs_addr[2 + 2 * b], ea[b]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [4:0] e [7] = '{5'b00000, 5'b10001, 5'b11001, 5'b10001, 5'b11001, 5'b00101, 5'b00000};
        run(8'h40, 4'h3, 4, 64'h0, 64'h0);
        #2;
        checks++;
        if ({rd, busy} !== 2'b11) begin
            failures++;
            $display("FAIL midrst_pre got=%b exp=11", {rd, busy});
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({rd, beat, ds, err, busy} !== 5'b00000) begin
            failures++;
            $display("FAIL midrst_outputs got=%b exp=00000", {rd, beat, ds, err, busy});
        end
        checks++;
        if (addr !== 8'h00) begin
            failures++;
            $display("FAIL midrst_addr got=%h exp=00", addr);
        end
        @(posedge clk);
        #2;
        checks++;
        if (ds !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_ds got=%b exp=0", ds);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        run(8'h60, 4'h1, 7, 64'h0, 64'h0);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (obs_sig[k] !== e[k]) begin
                failures++;
                $display("FAIL postrst_sig cyc=%0d got=%b exp=%b", k, obs_sig[k], e[k]);
            end
        end
        checks++;
        if (obs_addr[2] !== 8'h60 || obs_addr[4] !== 8'h61) begin
            failures++;
            $display("FAIL postrst_addr got=%h,%h exp=60,61", obs_addr[2], obs_addr[4]);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_four_beats();
        test_retry_once();
        test_abort();
        test_wrap_ignore_go();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/burst_read_ctrl.md
# burst_read_ctrl

Parametrised burst read sequencer for a wait-stated memory port. On a `go` pulse it captures a base address and beat count. For each beat it issues `rd` and honours the memory's `ws` wait-state signal with a bounded retry limit, stepping the address between beats. It ends with a one-cycle `ds` done strobe, plus `err` if the retry limit aborted the burst. It sits between the bus-side request logic and the memory wait-state interface, replacing the fixed single-beat read FSM.

## Interface
- `ADDR_W`, 8: address width; `addr` wraps modulo 2^ADDR_W.
- `LEN_W`, 4: width of `burst_len`; beats per burst = `burst_len` + 1 (1 to 2^LEN_W).
- `MAX_RETRY`, 3: `ws`=1 retries allowed per beat; 0 = no retries. Retry counter width = clog2(MAX_RETRY+1), minimum 1.
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `go`  in  1  start request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first beat address; captured when `go` is accepted.
- `burst_len`  in  LEN_W  beats minus one; captured when `go` is accepted.
- `ws`  in  1  memory wait state; sampled only in DELAY.
- `rd`  out  1  read strobe; combinational from state.
- `addr`  out  ADDR_W  registered current beat address.
- `beat`  out  1  beat data valid; combinational, = DELAY & !ws.
- `ds`  out  1  done strobe; one cycle in DONE.
- `err`  out  1  = DONE & abort flag.
- `busy`  out  1  = state != IDLE.

## Operation
- State machine states: IDLE, READ, DELAY, DONE. Encoding is 4-bit one-hot: IDLE=0001, READ=0010, DELAY=0100, DONE=1000.
- Registered state: `addr`, `beat_cnt` (LEN_W bits), `len_q`, `retry_cnt` and `abort`.
- IDLE
  - With `go`=1: `addr`<=`base_addr`, `len_q`<=`burst_len`, `beat_cnt`<=0, `retry_cnt`<=0, `abort`<=0, then go to READ.
  - Otherwise stay in IDLE.
- READ
  - `rd`=1.
  - Always go to DELAY.
- DELAY, `rd`=1. Priority order:
  1. `ws`=1 and `retry_cnt`<MAX_RETRY: `retry_cnt`++, go to READ. `addr` is unchanged; the same beat is retried.
  2. `ws`=1 and `retry_cnt`==MAX_RETRY: `abort`<=1, go to DONE.
  3. `ws`=0 and `beat_cnt`==`len_q`: `beat`=1, go to DONE.
  4. `ws`=0 otherwise: `beat`=1, `addr`<=`addr`+1 (wraps), `beat_cnt`++, `retry_cnt`<=0, go to READ.
- DONE
  - `ds`=1; `err`=`abort`.
  - Always go to IDLE; `go` in DONE is ignored.
- `go` in any state other than IDLE is ignored; the captured `base_addr` and `burst_len` are held for the whole burst.
- Illegal state encoding: all outputs 0; next state IDLE.
- `rd`, `ds`, `beat`, `err` and `busy` are Mealy/combinational outputs. Downstream logic must register them if it needs them glitch-free.

## Timing
- Reset (async, `rstn`=0): state=IDLE, `addr`=0, counters=0, `abort`=0. Outputs: `rd`=0, `beat`=0, `ds`=0, `err`=0, `busy`=0.
- Reset asserted mid-burst aborts the burst immediately. No `ds` is produced.
- Cycle numbering, counted from the cycle `go` is sampled in IDLE (cycle 0):
  - Cycle 1 is READ.
  - Each beat with no wait costs 2 cycles (READ + DELAY).
  - Each retry adds 2 cycles.
- With zero retries, `ds` is asserted in cycle 2N+1 for N beats. The block is back in IDLE, ready for the next `go`, at cycle 2N+2.
- Minimum interval between accepted `go` pulses: 2N+2 cycles.
- `addr` changes on the clock edge that leaves DELAY with `ws`=0 and more beats remaining. It is stable through each READ/DELAY pair.
- Burst-length boundaries:
  - `burst_len`=0: single beat.
  - `burst_len`=2^LEN_W−1: maximum burst. `beat_cnt` compares equal before it would overflow.

## Test plan
- Reset, then `go` with `base_addr`=0x10, `burst_len`=0, `ws`=0 -> `rd`=1 in cycles 1–2; `beat`=1 in cycle 2 with `addr`=0x10; `ds`=1, `err`=0 in cycle 3; `busy`=0 in cycle 4.
- `base_addr`=0x20, `burst_len`=3, `ws`=0 -> four `beat` pulses in cycles 2, 4, 6, 8 with `addr` 0x20..0x23; `ds` in cycle 9.
- `burst_len`=1, `ws`=1 on the first DELAY only -> first beat retried; `addr` stays 0x20 for the retry; `beat` pulses in cycles 4 and 6; `ds` in cycle 7, `err`=0.
- MAX_RETRY=3, `ws` held at 1 -> 3 retries, then the 4th `ws`=1 aborts; `ds`=1 and `err`=1 together in cycle 9; no `beat` pulses.
- `base_addr`=0xFE, `burst_len`=2 (ADDR_W=8) -> `addr` sequence 0xFE, 0xFF, 0x00; `go` pulses during the burst are ignored, with no restart and no change to `addr`.
- `rstn` driven low in DELAY of beat 2 -> all outputs 0 asynchronously; after release, a new `go` runs a clean burst from the new `base_addr`.
